// File: rtl/rsa_engine_arbiter.sv
// ---------------------------------------------------------------------------
// rsa_engine_arbiter
//   Shares one constant-time RSA modular-exponentiation engine between
//   NUM_REQ requesters. Grants round-robin, latches the winner's operands,
//   pulses the engine start, then waits for engine finish (or a watchdog
//   timeout) and hands the result back with a one-cycle done pulse.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   req                per-requester level request
//   req_c/req_d/req_n  packed operands, requester i at [i*2*WIDTH +: 2*WIDTH]
//   ack                one-hot, one cycle, operands latched
//   done               one-hot, one cycle, result valid
//   result             result for the requester flagged by done
//   timeout_err        high with done when the job was aborted
//   busy               high whenever the arbiter is not idle
//   eng_start          one-cycle engine start
//   eng_c/eng_d/eng_n  latched operands, stable from ISSUE to the next grant
//   eng_m, eng_finish  engine result and its one-cycle completion pulse
// ---------------------------------------------------------------------------
module rsa_engine_arbiter #(
  parameter int          WIDTH   = 8,
  parameter int          NUM_REQ = 4,
  parameter logic [31:0] TIMEOUT = 32'd4000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*2*WIDTH-1:0]   req_c,
  input  logic [NUM_REQ*2*WIDTH-1:0]   req_d,
  input  logic [NUM_REQ*2*WIDTH-1:0]   req_n,
  output logic [NUM_REQ-1:0]           ack,
  output logic [NUM_REQ-1:0]           done,
  output logic [2*WIDTH-1:0]           result,
  output logic                         timeout_err,
  output logic                         busy,
  output logic                         eng_start,
  output logic [2*WIDTH-1:0]           eng_c,
  output logic [2*WIDTH-1:0]           eng_d,
  output logic [2*WIDTH-1:0]           eng_n,
  input  logic [2*WIDTH-1:0]           eng_m,
  input  logic                         eng_finish
);

  localparam int OW    = 2 * WIDTH;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   last_grant;
  logic [31:0]        timer;
  logic               to_flag;

  logic [IDX_W-1:0]   win_idx;
  logic               win_found;

  // Round-robin search: start one past the last grant and wrap modulo NUM_REQ,
  // so the most recently served requester has the lowest priority.
  always_comb begin
    int cand;
    // NOTE: every variable written here gets a default first, so no latch is
    // inferred on the paths where no requester is found.
    win_idx   = '0;
    win_found = 1'b0;
    cand      = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(last_grant) + off) % NUM_REQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    return NUM_REQ'(1) << i;
  endfunction

  // Single FSM; every output is a register updated on the state transition,
  // so nothing downstream sees a combinational path from req.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      last_grant  <= IDX_W'(NUM_REQ - 1);
      timer       <= '0;
      to_flag     <= 1'b0;
      eng_c       <= '0;
      eng_d       <= '0;
      eng_n       <= '0;
      result      <= '0;
      ack         <= '0;
      done        <= '0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      eng_start   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            idx       <= win_idx;
            eng_c     <= req_c[win_idx*OW +: OW];
            eng_d     <= req_d[win_idx*OW +: OW];
            eng_n     <= req_n[win_idx*OW +: OW];
            ack       <= onehot(win_idx);
            eng_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          ack        <= '0;
          eng_start  <= 1'b0;
          last_grant <= idx;
          timer      <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          timer <= timer + 32'd1;
          // A finish in the same cycle as the timeout still delivers the result.
          if (eng_finish) begin
            result      <= eng_m;
            to_flag     <= 1'b0;
            timeout_err <= 1'b0;
            done        <= onehot(idx);
            state       <= DONE;
          end else if (timer == TIMEOUT - 32'd1) begin
            result      <= '0;
            to_flag     <= 1'b1;
            timeout_err <= 1'b1;
            done        <= onehot(idx);
            state       <= DONE;
          end
        end
        DONE: begin
          done        <= '0;
          timeout_err <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_engine_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rsa_engine_arbiter
//   Directed bench for rsa_engine_arbiter with a mock engine of programmable
//   latency. Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_rsa_engine_arbiter;

  localparam int          W   = 8;
  localparam int          N   = 4;
  localparam int          OW  = 2 * W;
  localparam logic [31:0] TO  = 32'd20;
  localparam int          LIM = 60;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N*OW-1:0]   req_c, req_d, req_n;
  logic [N-1:0]      ack, done;
  logic [OW-1:0]     result;
  logic              timeout_err, busy, eng_start;
  logic [OW-1:0]     eng_c, eng_d, eng_n;
  logic [OW-1:0]     eng_m;
  logic              eng_finish;

  // Mock engine controls and outputs
  logic              mock_en;
  int                mock_lat;
  logic              mock_fixed_en;
  logic [OW-1:0]     mock_fixed;
  logic              mock_fin;
  logic [OW-1:0]     mock_m;
  logic              spurious;

  assign eng_finish = mock_fin | spurious;
  assign eng_m      = spurious ? 16'hAAAA : mock_m;

  int total = 0;
  int bad   = 0;

  logic [OW-1:0] tc [N] = '{16'h1234, 16'h0042, 16'h0101, 16'hBEEF};
  logic [OW-1:0] td [N] = '{16'h0003, 16'h0007, 16'h0011, 16'h0002};
  logic [OW-1:0] tn [N] = '{16'h1F01, 16'h00BB, 16'h0D21, 16'hFFF1};

  rsa_engine_arbiter #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req),
    .req_c(req_c), .req_d(req_d), .req_n(req_n),
    .ack(ack), .done(done), .result(result), .timeout_err(timeout_err),
    .busy(busy), .eng_start(eng_start),
    .eng_c(eng_c), .eng_d(eng_d), .eng_n(eng_n),
    .eng_m(eng_m), .eng_finish(eng_finish)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] ref_m(input logic [OW-1:0] c, d, n);
    longint r, b;
    r = 1;
    b = longint'(c) % longint'(n);
    for (int i = 0; i < OW; i++) begin
      if (d[i]) r = (r * b) % longint'(n);
      b = (b * b) % longint'(n);
    end
    return OW'(r);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Mock engine: counts mock_lat falling edges after eng_start, then pulses
  // finish for one cycle with modexp of the operands it captured.
  initial begin
    int cnt;
    logic [OW-1:0] cap_c, cap_d, cap_n;
    cnt = 0; mock_fin = 1'b0; mock_m = '0;
    cap_c = '0; cap_d = '0; cap_n = '0;
    forever begin
      @(negedge clk);
      mock_fin = 1'b0;
      if (rst) cnt = 0;
      else if (cnt != 0) begin
        cnt--;
        if (cnt == 0) begin
          mock_fin = 1'b1;
          mock_m   = mock_fixed_en ? mock_fixed : ref_m(cap_c, cap_d, cap_n);
        end
      end else if (eng_start && mock_en) begin
        cnt = mock_lat;
        cap_c = eng_c; cap_d = eng_d; cap_n = eng_n;
      end
    end
  end

  // Waits for an ack and checks the grant and the latched operands.
  task automatic await_ack(input string tag, input int exp_idx, output int lat);
    lat = 0;
    for (int k = 1; k <= LIM; k++) begin
      @(negedge clk);
      if (ack != '0) begin lat = k; break; end
    end
    if (lat == 0) check({tag, "_seen"}, 32'd0, 32'd1);
    else begin
      check({tag, "_ack"}, 32'(ack), 32'(N'(1) << exp_idx));
      check({tag, "_start"}, 32'(eng_start), 32'd1);
      check({tag, "_c"}, 32'(eng_c), 32'(tc[exp_idx]));
      check({tag, "_d"}, 32'(eng_d), 32'(td[exp_idx]));
      check({tag, "_n"}, 32'(eng_n), 32'(tn[exp_idx]));
    end
  endtask

  // Waits for done and checks it; exp_lat==0 skips the latency check.
  task automatic await_done(input string tag, input int exp_idx, input logic [OW-1:0] exp_res,
                            input logic exp_to, input int exp_lat);
    int lat;
    lat = 0;
    for (int k = 1; k <= LIM; k++) begin
      @(negedge clk);
      if (done != '0) begin lat = k; break; end
    end
    if (lat == 0) check({tag, "_done_seen"}, 32'd0, 32'd1);
    else begin
      check({tag, "_done"}, 32'(done), 32'(N'(1) << exp_idx));
      check({tag, "_result"}, 32'(result), 32'(exp_res));
      check({tag, "_to_err"}, 32'(timeout_err), 32'(exp_to));
      if (exp_lat != 0) check({tag, "_done_lat"}, 32'(lat), 32'(exp_lat));
      @(negedge clk);
      check({tag, "_done_clr"}, 32'(done), 32'd0);
      check({tag, "_idle"}, 32'(busy), 32'd0);
      check({tag, "_held"}, 32'(result), 32'(exp_res));
    end
  endtask

  initial begin
    int lat;
    rst = 1'b1; req = '0; spurious = 1'b0;
    mock_en = 1'b1; mock_lat = 10; mock_fixed_en = 1'b0; mock_fixed = '0;
    for (int i = 0; i < N; i++) begin
      req_c[i*OW +: OW] = tc[i];
      req_d[i*OW +: OW] = td[i];
      req_n[i*OW +: OW] = tn[i];
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(eng_start), 32'd0);
    check("rst_to_err", 32'(timeout_err), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_eng_c", 32'(eng_c), 32'd0);
    rst = 1'b0;

    // Single request, engine latency 10, fixed result 0x0055
    @(negedge clk);
    mock_fixed_en = 1'b1; mock_fixed = 16'h0055;
    req = 4'b0010;
    await_ack("t1", 1, lat);
    req = '0;
    check("t1_ack_lat", 32'(lat), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    await_done("t1", 1, 16'h0055, 1'b0, 11);
    mock_fixed_en = 1'b0;

    // Simultaneous requests from reset: order 0,1,2,3
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < N; k++) begin
      await_ack($sformatf("t2_%0d", k), k, lat);
      req[k] = 1'b0;
      await_done($sformatf("t2_%0d", k), k, ref_m(tc[k], td[k], tn[k]), 1'b0, 11);
    end

    // Fairness: req0 held throughout, req2 raised during job 1 -> 0,2,0
    req = 4'b0001;
    await_ack("t3_a", 0, lat);
    repeat (2) @(negedge clk);
    req[2] = 1'b1;
    await_done("t3_a", 0, ref_m(tc[0], td[0], tn[0]), 1'b0, 0);
    await_ack("t3_b", 2, lat);
    req[2] = 1'b0;
    await_done("t3_b", 2, ref_m(tc[2], td[2], tn[2]), 1'b0, 11);
    await_ack("t3_c", 0, lat);
    req[0] = 1'b0;
    await_done("t3_c", 0, ref_m(tc[0], td[0], tn[0]), 1'b0, 11);

    // Timeout: engine never finishes; done 21 cycles after ISSUE
    mock_en = 1'b0;
    req = 4'b0010;
    await_ack("t4", 1, lat);
    req = '0;
    await_done("t4", 1, 16'h0000, 1'b1, 21);
    @(negedge clk); spurious = 1'b1;
    @(negedge clk); spurious = 1'b0;
    check("t4_late_done", 32'(done), 32'd0);
    check("t4_late_busy", 32'(busy), 32'd0);
    check("t4_late_result", 32'(result), 32'd0);
    mock_en = 1'b1;
    req = 4'b1000;
    await_ack("t4_next", 3, lat);
    req = '0;
    await_done("t4_next", 3, ref_m(tc[3], td[3], tn[3]), 1'b0, 11);

    // Finish and timeout in the same cycle: finish wins
    mock_lat = 20;
    req = 4'b0100;
    await_ack("t5", 2, lat);
    req = '0;
    await_done("t5", 2, ref_m(tc[2], td[2], tn[2]), 1'b0, 21);
    mock_lat = 10;

    // Reset in the middle of WAIT
    req = 4'b0010;
    await_ack("t6", 1, lat);
    req = '0;
    repeat (3) @(negedge clk);
    check("t6_busy_wait", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_ack", 32'(ack), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_start", 32'(eng_start), 32'd0);
    check("t6_to_err", 32'(timeout_err), 32'd0);
    check("t6_result", 32'(result), 32'd0);
    check("t6_eng_c", 32'(eng_c), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    req = 4'b1111;
    await_ack("t6_after", 0, lat);
    req = '0;
    check("t6_after_lat", 32'(lat), 32'd1);
    await_done("t6_after", 0, ref_m(tc[0], td[0], tn[0]), 1'b0, 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
